// File: rtl/periph_fifo_id_flex.sv
// periph_fifo_id_flex: ID-tagged request FIFO with an outstanding-response limiter.
// Define PERIPH_FIFO_RESP_BUF_EN to register the response path (1-cycle latency).
module periph_fifo_id_flex #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 8,
   parameter int BE_WIDTH        = DATA_WIDTH / 8,
   parameter int REQ_DEPTH       = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                test_en_i,
   input  logic                                data_req_i,
   input  logic [ADDR_WIDTH-1:0]               data_add_i,
   input  logic                                data_wen_i,
   input  logic [DATA_WIDTH-1:0]               data_wdata_i,
   input  logic [BE_WIDTH-1:0]                 data_be_i,
   input  logic [ID_WIDTH-1:0]                 data_id_i,
   output logic                                data_gnt_o,
   output logic                                data_req_o,
   output logic [ADDR_WIDTH-1:0]               data_add_o,
   output logic                                data_wen_o,
   output logic [DATA_WIDTH-1:0]               data_wdata_o,
   output logic [BE_WIDTH-1:0]                 data_be_o,
   output logic [ID_WIDTH-1:0]                 data_id_o,
   input  logic                                data_gnt_i,
   input  logic                                data_r_valid_i,
   input  logic                                data_r_opc_i,
   input  logic [ID_WIDTH-1:0]                 data_r_id_i,
   input  logic [DATA_WIDTH-1:0]               data_r_rdata_i,
   output logic                                data_r_valid_o,
   output logic                                data_r_opc_o,
   output logic [ID_WIDTH-1:0]                 data_r_id_o,
   output logic [DATA_WIDTH-1:0]               data_r_rdata_o,
   output logic [$clog2(REQ_DEPTH):0]          fifo_level_o,
   output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
   output logic                                resp_err_o
);

   localparam int PTR_W = $clog2(REQ_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] add;
      logic                  wen;
      logic [DATA_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   be;
      logic [ID_WIDTH-1:0]   id;
   } entry_t;

   entry_t            mem_q [REQ_DEPTH];
   entry_t            mem_d [REQ_DEPTH];
   entry_t            wr_entry_s;
   entry_t            head_s;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              err_q, err_d;
   logic              push_s, pop_s;
   logic              unused_test_en_s;

   assign unused_test_en_s = test_en_i;

   assign wr_entry_s = '{add: data_add_i, wen: data_wen_i, wdata: data_wdata_i,
                         be: data_be_i, id: data_id_i};
   assign head_s     = mem_q[rptr_q];

   // Grant and issue depend only on stored state, never on data_gnt_i.
   assign data_gnt_o = (level_q != LVL_W'(REQ_DEPTH));
   assign data_req_o = (level_q != LVL_W'(0)) && (out_q < OUT_W'(MAX_OUTSTANDING));
   assign push_s     = data_req_i && data_gnt_o;
   assign pop_s      = data_req_o && data_gnt_i;

   assign data_add_o   = head_s.add;
   assign data_wen_o   = head_s.wen;
   assign data_wdata_o = head_s.wdata;
   assign data_be_o    = head_s.be;
   assign data_id_o    = head_s.id;
   assign fifo_level_o  = level_q;
   assign outstanding_o = out_q;
   assign resp_err_o    = err_q;

   // Next-state for storage, pointers, level, outstanding count and error flag.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      out_d   = out_q;
      err_d   = err_q;
      if (push_s) begin
         mem_d[wptr_q] = wr_entry_s;
         wptr_d        = wptr_q + PTR_W'(1);
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_s) begin
         rptr_d = rptr_q + PTR_W'(1);
      end else begin
         rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      // A response with nothing pending (and no issue this cycle) is an underflow.
      case ({pop_s, data_r_valid_i})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01: begin
            if (out_q == OUT_W'(0)) begin
               out_d = out_q;
               err_d = 1'b1;
            end else begin
               out_d = out_q - OUT_W'(1);
            end
         end
         default: out_d = out_q;
      endcase
   end

   // State registers; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < REQ_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= PTR_W'(0);
         rptr_q  <= PTR_W'(0);
         level_q <= LVL_W'(0);
         out_q   <= OUT_W'(0);
         err_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

`ifdef PERIPH_FIFO_RESP_BUF_EN
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_opc_q, rsp_opc_d;
   logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   // Response slice: valid loads every cycle, payload only with a valid response.
   always_comb begin
      rsp_valid_d = data_r_valid_i;
      rsp_opc_d   = rsp_opc_q;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = rsp_rdata_q;
      if (data_r_valid_i) begin
         rsp_opc_d   = data_r_opc_i;
         rsp_id_d    = data_r_id_i;
         rsp_rdata_d = data_r_rdata_i;
      end else begin
         rsp_opc_d   = rsp_opc_q;
         rsp_id_d    = rsp_id_q;
         rsp_rdata_d = rsp_rdata_q;
      end
   end

   // Response slice registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rsp_opc_q   <= 1'b0;
         rsp_id_q    <= ID_WIDTH'(0);
         rsp_rdata_q <= DATA_WIDTH'(0);
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_opc_q   <= rsp_opc_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign data_r_valid_o = rsp_valid_q;
   assign data_r_opc_o   = rsp_opc_q;
   assign data_r_id_o    = rsp_id_q;
   assign data_r_rdata_o = rsp_rdata_q;
`else
   assign data_r_valid_o = data_r_valid_i;
   assign data_r_opc_o   = data_r_opc_i;
   assign data_r_id_o    = data_r_id_i;
   assign data_r_rdata_o = data_r_rdata_i;
`endif

endmodule

// File: tb/tb_periph_fifo_id_flex.sv
// Directed bench for periph_fifo_id_flex with a queue-based reference model.
// Builds with or without PERIPH_FIFO_RESP_BUF_EN; response latency expectations follow it.
module tb_periph_fifo_id_flex;

   localparam int AW = 32, DW = 32, IW = 8, BW = 4, DEPTH = 4, MAXO = 4;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          test_en_i = 1'b0;
   logic          data_req_i = 1'b0;
   logic [AW-1:0] data_add_i = '0;
   logic          data_wen_i = 1'b0;
   logic [DW-1:0] data_wdata_i = '0;
   logic [BW-1:0] data_be_i = '0;
   logic [IW-1:0] data_id_i = '0;
   logic          data_gnt_o, data_req_o, data_wen_o;
   logic [AW-1:0] data_add_o;
   logic [DW-1:0] data_wdata_o;
   logic [BW-1:0] data_be_o;
   logic [IW-1:0] data_id_o;
   logic          data_gnt_i = 1'b0;
   logic          data_r_valid_i = 1'b0;
   logic          data_r_opc_i = 1'b0;
   logic [IW-1:0] data_r_id_i = '0;
   logic [DW-1:0] data_r_rdata_i = '0;
   logic          data_r_valid_o, data_r_opc_o;
   logic [IW-1:0] data_r_id_o;
   logic [DW-1:0] data_r_rdata_o;
   logic [2:0]    fifo_level_o;
   logic [2:0]    outstanding_o;
   logic          resp_err_o;

   periph_fifo_id_flex dut (
      .clk_i(clk), .rst_ni(rst_ni), .test_en_i(test_en_i),
      .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
      .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_id_i(data_id_i),
      .data_gnt_o(data_gnt_o),
      .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
      .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_id_o(data_id_o),
      .data_gnt_i(data_gnt_i),
      .data_r_valid_i(data_r_valid_i), .data_r_opc_i(data_r_opc_i),
      .data_r_id_i(data_r_id_i), .data_r_rdata_i(data_r_rdata_i),
      .data_r_valid_o(data_r_valid_o), .data_r_opc_o(data_r_opc_o),
      .data_r_id_o(data_r_id_o), .data_r_rdata_o(data_r_rdata_o),
      .fifo_level_o(fifo_level_o), .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of pending requests, an integer pending-response count.
   typedef struct packed {
      logic [AW-1:0] add;
      logic          wen;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
      logic [IW-1:0] id;
   } req_t;

   req_t          mq[$];
   int            m_out = 0;
   bit            m_err = 1'b0;
   logic          s_rv = 1'b0, s_opc = 1'b0;
   logic [IW-1:0] s_rid = '0;
   logic [DW-1:0] s_rdata = '0;

   initial forever begin
      bit   gnt_m, req_m, push_m, pop_m;
      int   nxt;
      req_t r;
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) begin
         mq.delete();
         m_out = 0;
         m_err = 1'b0;
         s_rv = 1'b0; s_opc = 1'b0; s_rid = '0; s_rdata = '0;
      end else begin
         gnt_m  = (mq.size() != DEPTH);
         req_m  = (mq.size() != 0) && (m_out < MAXO);
         push_m = data_req_i && gnt_m;
         pop_m  = req_m && data_gnt_i;
         r = '{add: data_add_i, wen: data_wen_i, wdata: data_wdata_i, be: data_be_i, id: data_id_i};
         if (pop_m) void'(mq.pop_front());
         if (push_m) mq.push_back(r);
         nxt = m_out + int'(pop_m) - int'(data_r_valid_i);
         if (nxt < 0) begin
            m_err = 1'b1;
            nxt = 0;
         end
         m_out = nxt;
         s_rv = data_r_valid_i;
         if (data_r_valid_i) begin
            s_opc = data_r_opc_i; s_rid = data_r_id_i; s_rdata = data_r_rdata_i;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      req_t h;
      @(negedge clk);
      chk("gnt", 64'(data_gnt_o), 64'(mq.size() != DEPTH));
      chk("req", 64'(data_req_o), 64'((mq.size() != 0) && (m_out < MAXO)));
      chk("level", 64'(fifo_level_o), 64'(mq.size()));
      chk("outstanding", 64'(outstanding_o), 64'(m_out));
      chk("resp_err", 64'(resp_err_o), 64'(m_err));
      if (mq.size() != 0) begin
         h = mq[0];
         chk("head_add", 64'(data_add_o), 64'(h.add));
         chk("head_wen", 64'(data_wen_o), 64'(h.wen));
         chk("head_wdata", 64'(data_wdata_o), 64'(h.wdata));
         chk("head_be", 64'(data_be_o), 64'(h.be));
         chk("head_id", 64'(data_id_o), 64'(h.id));
      end
`ifdef PERIPH_FIFO_RESP_BUF_EN
      chk("r_valid", 64'(data_r_valid_o), 64'(s_rv));
      chk("r_opc", 64'(data_r_opc_o), 64'(s_opc));
      chk("r_id", 64'(data_r_id_o), 64'(s_rid));
      chk("r_rdata", 64'(data_r_rdata_o), 64'(s_rdata));
`else
      chk("r_valid", 64'(data_r_valid_o), 64'(data_r_valid_i));
      chk("r_opc", 64'(data_r_opc_o), 64'(data_r_opc_i));
      chk("r_id", 64'(data_r_id_o), 64'(data_r_id_i));
      chk("r_rdata", 64'(data_r_rdata_o), 64'(data_r_rdata_i));
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [IW-1:0] id);
      data_req_i   = v;
      data_id_i    = id;
      data_add_i   = {24'h0000A0, id};
      data_wen_i   = id[0];
      data_wdata_i = {id, ~id, id, 8'h5A};
      data_be_i    = id[3:0];
   endtask

   // Respond in the same cycle as each handshake so the count never builds up.
   task automatic echo_resp(inout int seen[$]);
      logic hs;
      hs = data_req_o && data_gnt_i;
      data_r_valid_i = hs;
      data_r_opc_i   = 1'b0;
      data_r_id_i    = data_id_o;
      data_r_rdata_i = data_wdata_o;
      if (hs) seen.push_back(int'(data_id_o));
   endtask

   initial begin
      int   seen[$];
      int   k, guard, hs_cnt, exp_id;
      logic acc;

      // Reset values
      #12;
      chk("rst_gnt", 64'(data_gnt_o), 64'd1);
      chk("rst_req", 64'(data_req_o), 64'd0);
      chk("rst_level", 64'(fifo_level_o), 64'd0);
      chk("rst_out", 64'(outstanding_o), 64'd0);
      chk("rst_err", 64'(resp_err_o), 64'd0);
      chk("rst_id", 64'(data_id_o), 64'd0);
      chk("rst_add", 64'(data_add_o), 64'd0);
      chk("rst_rvalid", 64'(data_r_valid_o), 64'd0);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      cyc();

      // Fill with downstream grant held low
      data_gnt_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_req(1'b1, 8'(8'h10 + i));
         chk("fill_gnt", 64'(data_gnt_o), 64'(i < 4));
         cyc();
      end
      set_req(1'b0, 8'h00);
      chk("fill_level", 64'(fifo_level_o), 64'd4);
      chk("fill_gnt_full", 64'(data_gnt_o), 64'd0);
      chk("fill_head_id", 64'(data_id_o), 64'h10);
      chk("fill_req", 64'(data_req_o), 64'd1);

      // Drain with wrap while pushing 0x20..0x27
      data_gnt_i = 1'b1;
      k = 0;
      guard = 0;
      while (k < 8 && guard < 40) begin
         set_req(1'b1, 8'(8'h20 + k));
         acc = data_gnt_o;
         echo_resp(seen);
         cyc();
         if (acc) k++;
         guard++;
      end
      set_req(1'b0, 8'h00);
      while (data_req_o && guard < 40) begin
         echo_resp(seen);
         cyc();
         guard++;
      end
      data_r_valid_i = 1'b0;
      chk("drain_timeout", 64'(guard < 40), 64'd1);
      chk("drain_count", 64'(seen.size()), 64'd12);
      for (int i = 0; i < 12; i++) begin
         exp_id = (i < 4) ? (16 + i) : (32 + i - 4);
         chk("drain_order", (i < seen.size()) ? 64'(seen[i]) : 64'hFFFF, 64'(exp_id));
      end
      chk("drain_out", 64'(outstanding_o), 64'd0);
      chk("drain_err", 64'(resp_err_o), 64'd0);

      // Outstanding limit: 6 requests, no responses
      hs_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         set_req(1'b1, 8'(8'h30 + i));
         if (data_req_o && data_gnt_i) hs_cnt++;
         cyc();
      end
      set_req(1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         if (data_req_o && data_gnt_i) hs_cnt++;
         cyc();
      end
      chk("limit_handshakes", 64'(hs_cnt), 64'd4);
      chk("limit_req", 64'(data_req_o), 64'd0);
      chk("limit_out", 64'(outstanding_o), 64'd4);
      chk("limit_level", 64'(fifo_level_o), 64'd2);
      data_r_valid_i = 1'b1;
      data_r_id_i    = 8'h30;
      data_r_rdata_i = 32'h00000030;
      cyc();
      data_r_valid_i = 1'b0;
      chk("limit_reissue_req", 64'(data_req_o), 64'd1);
      chk("limit_reissue_out", 64'(outstanding_o), 64'd3);
      chk("limit_reissue_id", 64'(data_id_o), 64'h34);
      cyc();
      chk("limit_again_req", 64'(data_req_o), 64'd0);
      chk("limit_again_out", 64'(outstanding_o), 64'd4);
      chk("limit_again_level", 64'(fifo_level_o), 64'd1);

      // Simultaneous issue and response at outstanding 3
      data_r_valid_i = 1'b1;
      data_r_id_i    = 8'h31;
      cyc();
      chk("simul_pre_out", 64'(outstanding_o), 64'd3);
      chk("simul_pre_req", 64'(data_req_o), 64'd1);
      data_r_id_i = 8'h32;
      cyc();
      chk("simul_out", 64'(outstanding_o), 64'd3);
      chk("simul_level", 64'(fifo_level_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         data_r_id_i = 8'(8'h33 + i);
         cyc();
      end
      data_r_valid_i = 1'b0;
      chk("settle_out", 64'(outstanding_o), 64'd0);
      chk("settle_err", 64'(resp_err_o), 64'd0);

      // Underflow: response with nothing pending
      data_r_valid_i = 1'b1;
      data_r_opc_i   = 1'b1;
      data_r_id_i    = 8'h55;
      data_r_rdata_i = 32'hDEADBEEF;
`ifndef PERIPH_FIFO_RESP_BUF_EN
      chk("uf_rdata_comb", 64'(data_r_rdata_o), 64'hDEADBEEF);
      chk("uf_rvalid_comb", 64'(data_r_valid_o), 64'd1);
`endif
      cyc();
      data_r_valid_i = 1'b0;
      data_r_opc_i   = 1'b0;
      data_r_id_i    = 8'h00;
      data_r_rdata_i = 32'h0;
`ifdef PERIPH_FIFO_RESP_BUF_EN
      chk("uf_rvalid_reg", 64'(data_r_valid_o), 64'd1);
      chk("uf_rdata_reg", 64'(data_r_rdata_o), 64'hDEADBEEF);
`else
      chk("uf_rvalid_next", 64'(data_r_valid_o), 64'd0);
`endif
      chk("uf_err", 64'(resp_err_o), 64'd1);
      chk("uf_out", 64'(outstanding_o), 64'd0);
      for (int i = 0; i < 3; i++) cyc();
      chk("uf_err_sticky", 64'(resp_err_o), 64'd1);

      // Reset mid-operation with level 3 and outstanding 2
      data_gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, 8'(8'h40 + i));
         cyc();
      end
      data_gnt_i = 1'b1;
      set_req(1'b1, 8'h44);
      cyc();
      cyc();
      data_gnt_i = 1'b0;
      set_req(1'b0, 8'h00);
      chk("pre_rst_level", 64'(fifo_level_o), 64'd3);
      chk("pre_rst_out", 64'(outstanding_o), 64'd2);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_req", 64'(data_req_o), 64'd0);
      chk("arst_gnt", 64'(data_gnt_o), 64'd1);
      chk("arst_level", 64'(fifo_level_o), 64'd0);
      chk("arst_out", 64'(outstanding_o), 64'd0);
      chk("arst_err", 64'(resp_err_o), 64'd0);
      @(negedge clk);
      #2;
      rst_ni = 1'b1;
      cyc();

      // Recovery after reset
      data_gnt_i = 1'b1;
      set_req(1'b1, 8'h50);
      cyc();
      set_req(1'b0, 8'h00);
      chk("post_rst_head", 64'(data_id_o), 64'h50);
      cyc();
      chk("post_rst_out", 64'(outstanding_o), 64'd1);
      chk("post_rst_level", 64'(fifo_level_o), 64'd0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
